frac_baud_tick_gen: RTL
=======================

// Module: frac_baud_tick_gen
// PURPOSE
//  Programmable fractional-N oversampling tick generator for the UART TX/RX datapath.
//  Emits one-cycle o_tick pulses at BAUDRATE*OVERSAMPLE average rate (integer+fractional divisor)
//  and an o_bit_tick every OVERSAMPLE ticks. Divisor is reloadable at runtime without glitches.
//  RX can re-phase the tick train on start-bit detection via i_resync.
// PARAMETERS
//  FREQUENCY   50_000_000  input clock frequency, Hz
//  BAUDRATE    9600        reset-time baud rate
//  OVERSAMPLE  16          ticks per bit, >=2, not necessarily a power of two
//  NB_INT      16          width of integer divisor part
//  NB_FRAC     8           width of fractional divisor part (units of 2^-NB_FRAC cycle)
// PORTS
//  i_clk         in   1                       system clock
//  i_reset       in   1                       synchronous, active-high reset
//  i_enable      in   1                       1 = run; 0 = freeze counters, no ticks
//  i_div_int     in   NB_INT                  new integer divisor (cycles per tick)
//  i_div_frac    in   NB_FRAC                 new fractional divisor
//  i_div_load    in   1                       1-cycle strobe: capture i_div_* into shadow
//  i_resync      in   1                       1-cycle strobe: restart tick phase
//  o_tick        out  1                       oversample tick, registered, 1 cycle wide
//  o_bit_tick    out  1                       coincident with o_tick that wraps o_sample_idx to 0
//  o_sample_idx  out  $clog2(OVERSAMPLE)      tick index within current bit
//  o_div_pending out  1                       shadow divisor captured, not yet active
// BEHAVIOUR
//  - One clock, i_clk; reset synchronous, active-high; i_reset has priority over all inputs.
//  - Reset divisor D0 = round(FREQUENCY*2^NB_FRAC/(BAUDRATE*OVERSAMPLE)); int=D0>>NB_FRAC, frac=D0 low bits
//    (defaults: 83333 -> int 325, frac 133).
//  - Reset: active={int0,frac0}, cnt=int0-1, acc=0, sample_idx=0, all outputs 0, pending=0.
//  - Enabled cycle: cnt==0 -> reload event: o_tick=1 next cycle; {carry,acc}=acc+active_frac;
//    cnt=active_int-1+carry. Else cnt=cnt-1. Tick period is int or int+1 cycles;
//    mean = int + frac/2^NB_FRAC exactly over 2^NB_FRAC ticks. First period after reset = int.
//  - sample_idx increments on each reload event, wraps OVERSAMPLE-1 -> 0; that reload also sets o_bit_tick.
//  - i_enable=0: cnt, acc, sample_idx hold; o_tick/o_bit_tick 0; pending shadow applied immediately.
//  - i_div_load: shadow <= i_div_*, pending=1; repeated loads: last wins. Shadow becomes active at the
//    next reload event strictly after the load cycle (load coincident with reload waits one more period).
//    Applying clears pending and acc; the reload computing that period uses the new divisor.
//  - Divisor clamp: captured int <2 is stored as 2 (period never below 2 cycles; o_tick never stuck high).
//  - i_resync (enabled or not): cnt=active_int-1 (pending shadow applied first), acc=0, sample_idx=0,
//    o_tick=o_bit_tick=0 next cycle. Resync coincident with reload: resync wins, no tick.
//  - Counter widths: cnt NB_INT bits, acc NB_FRAC bits, carry 1 bit; int+carry cannot overflow
//    because cnt holds int-1+carry <= int.
// STRUCTURE
//  - Package baud_pkg: D0 computation function, clog2 helper, MIN_DIV=2 constant, shared with UART TX/RX.
//  - One sub-module: baud_frac_acc (acc register + carry out, clear/hold inputs).
//  - Top holds shadow/active divisor, down-counter, sample index, output registers.
// TESTING
//  1 Defaults, reset then enable: sum of 256 consecutive tick periods = 83333 cycles; first period 325.
//  2 Load int=4 frac=0: after apply, o_tick every 4 cycles, o_bit_tick every 64, sample_idx 0..15.
//  3 Load int=3 frac=128: periods after apply 3,4,3,4...; average 3.5 over 256 ticks.
//  4 Load int=1 and int=0: both clamp to period 2; load int=5 coincident with reload -> applied one
//    period later, o_div_pending high throughout.
//  5 Resync at cnt mid-count: no tick that cycle, next o_tick exactly int cycles later, sample_idx=0.
//  6 i_enable low 10 cycles mid-period: period stretched by 10, no ticks; reset mid-operation
//    -> outputs 0 next cycle, first period 325 with default divisor.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared constants and elaboration-time helpers for the UART baud tick generators.
package baud_pkg;

   localparam int MIN_DIV = 2;

   function automatic int clog2(input int value);
      int bits;
      int rem;
      bits = 0;
      rem  = value - 1;
      while (rem > 0) begin
         bits = bits + 1;
         rem  = rem >> 1;
      end
      return bits;
   endfunction

   // Fixed-point divisor with NB_FRAC fraction bits, rounded to nearest.
   function automatic longint unsigned calc_d0(input longint unsigned freq,
                                              input longint unsigned baud,
                                              input longint unsigned os,
                                              input int              nb_frac);
      longint unsigned den;
      den = baud * os;
      return ((freq << (nb_frac + 1)) + den) / (den << 1);
   endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator: adds the fractional divisor on each step and
// reports the carry that stretches the next tick period by one cycle.
module baud_frac_acc #(
   parameter int NB_FRAC = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_clear,
   input  logic               i_step,
   input  logic [NB_FRAC-1:0] i_frac,
   output logic               o_carry,
   output logic [NB_FRAC-1:0] o_acc
);

   logic [NB_FRAC-1:0] acc_q;
   logic [NB_FRAC-1:0] acc_d;
   logic [NB_FRAC-1:0] base;
   logic [NB_FRAC:0]   sum;

   always_comb begin
      base    = i_clear ? '0 : acc_q;
      sum     = {1'b0, base} + {1'b0, i_frac};
      o_carry = sum[NB_FRAC];
      acc_d   = acc_q;
      if (i_step) begin
         acc_d = sum[NB_FRAC-1:0];
      end else if (i_clear) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign o_acc = acc_q;

endmodule

// File: rtl/frac_baud_tick_gen.sv
// Fractional-N oversampling tick generator: down-counter reloaded with int or
// int+1 cycles, shadowed divisor reload, sample index and resync for RX.
module frac_baud_tick_gen
   import baud_pkg::*;
#(
   parameter int FREQUENCY  = 50_000_000,
   parameter int BAUDRATE   = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int NB_INT     = 16,
   parameter int NB_FRAC    = 8
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_enable,
   input  logic [NB_INT-1:0]             i_div_int,
   input  logic [NB_FRAC-1:0]            i_div_frac,
   input  logic                          i_div_load,
   input  logic                          i_resync,
   output logic                          o_tick,
   output logic                          o_bit_tick,
   output logic [clog2(OVERSAMPLE)-1:0]  o_sample_idx,
   output logic                          o_div_pending
);

   localparam int                  IDX_W    = clog2(OVERSAMPLE);
   localparam longint unsigned     D0       = calc_d0(FREQUENCY, BAUDRATE, OVERSAMPLE, NB_FRAC);
   localparam logic [NB_INT-1:0]   INT_RAW  = NB_INT'(D0 >> NB_FRAC);
   localparam logic [NB_INT-1:0]   MIN_INT  = NB_INT'(MIN_DIV);
   localparam logic [NB_INT-1:0]   INT0     = (INT_RAW < MIN_INT) ? MIN_INT : INT_RAW;
   localparam logic [NB_FRAC-1:0]  FRAC0    = NB_FRAC'(D0);
   localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(OVERSAMPLE - 1);

   logic [NB_INT-1:0]  active_int_q, active_int_d;
   logic [NB_FRAC-1:0] active_frac_q, active_frac_d;
   logic [NB_INT-1:0]  shadow_int_q, shadow_int_d;
   logic [NB_FRAC-1:0] shadow_frac_q, shadow_frac_d;
   logic               pending_q, pending_d;
   logic [NB_INT-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               tick_q, tick_d;
   logic               bit_tick_q, bit_tick_d;

   logic               reload;
   logic               apply;
   logic [NB_INT-1:0]  eff_int;
   logic [NB_FRAC-1:0] eff_frac;
   logic               carry;
   logic [NB_FRAC-1:0] acc_unused;

   // A load landing on the reload cycle must not take effect until the next reload.
   assign reload   = i_enable && (cnt_q == '0);
   assign apply    = pending_q && (i_resync || !i_enable || (reload && !i_div_load));
   assign eff_int  = apply ? shadow_int_q  : active_int_q;
   assign eff_frac = apply ? shadow_frac_q : active_frac_q;

   baud_frac_acc #(
      .NB_FRAC (NB_FRAC)
   ) u_acc (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (apply || i_resync),
      .i_step  (reload && !i_resync),
      .i_frac  (eff_frac),
      .o_carry (carry),
      .o_acc   (acc_unused)
   );

   always_comb begin
      active_int_d  = active_int_q;
      active_frac_d = active_frac_q;
      shadow_int_d  = shadow_int_q;
      shadow_frac_d = shadow_frac_q;
      pending_d     = pending_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      tick_d        = 1'b0;
      bit_tick_d    = 1'b0;

      if (apply) begin
         active_int_d  = shadow_int_q;
         active_frac_d = shadow_frac_q;
         pending_d     = 1'b0;
      end
      if (i_div_load) begin
         shadow_int_d  = (i_div_int < MIN_INT) ? MIN_INT : i_div_int;
         shadow_frac_d = i_div_frac;
         pending_d     = 1'b1;
      end

      if (i_resync) begin
         cnt_d = eff_int - NB_INT'(1);
         idx_d = '0;
      end else if (reload) begin
         cnt_d      = eff_int - NB_INT'(1) + {{(NB_INT-1){1'b0}}, carry};
         tick_d     = 1'b1;
         bit_tick_d = (idx_q == IDX_LAST);
         idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else if (i_enable) begin
         cnt_d = cnt_q - NB_INT'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         active_int_q  <= INT0;
         active_frac_q <= FRAC0;
         shadow_int_q  <= INT0;
         shadow_frac_q <= FRAC0;
         pending_q     <= 1'b0;
         cnt_q         <= INT0 - NB_INT'(1);
         idx_q         <= '0;
         tick_q        <= 1'b0;
         bit_tick_q    <= 1'b0;
      end else begin
         active_int_q  <= active_int_d;
         active_frac_q <= active_frac_d;
         shadow_int_q  <= shadow_int_d;
         shadow_frac_q <= shadow_frac_d;
         pending_q     <= pending_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         tick_q        <= tick_d;
         bit_tick_q    <= bit_tick_d;
      end
   end

   assign o_tick        = tick_q;
   assign o_bit_tick    = bit_tick_q;
   assign o_sample_idx  = idx_q;
   assign o_div_pending = pending_q;

endmodule
